// File: rtl/ram_req_bridge_if.sv
// Core-side request/response channels plus the 2-read/1-write RAM port of ram_req_bridge.
// The bridge takes the slave view; the core and RAM model share the master view.
interface ram_req_bridge_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [1:0]  req_size;
   logic [2:0]  req_len;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_last;
   logic        resp_err;
   logic        ram_en;
   logic [63:0] ram_rIdx_0;
   logic [63:0] ram_rIdx_1;
   logic [63:0] ram_rdata_0;
   logic [63:0] ram_rdata_1;
   logic [63:0] ram_wIdx;
   logic [63:0] ram_wdata;
   logic [63:0] ram_wmask;
   logic        ram_wen;

   modport slave (
      input  req_valid, req_wen, req_addr, req_size, req_len, req_wdata,
      input  resp_ready, ram_rdata_0, ram_rdata_1,
      output req_ready, resp_valid, resp_rdata, resp_last, resp_err,
      output ram_en, ram_rIdx_0, ram_rIdx_1, ram_wIdx, ram_wdata, ram_wmask, ram_wen
   );

   modport master (
      output req_valid, req_wen, req_addr, req_size, req_len, req_wdata,
      output resp_ready, ram_rdata_0, ram_rdata_1,
      input  req_ready, resp_valid, resp_rdata, resp_last, resp_err,
      input  ram_en, ram_rIdx_0, ram_rIdx_1, ram_wIdx, ram_wdata, ram_wmask, ram_wen
   );
endinterface

// File: rtl/ram_req_bridge.sv
// Bridges byte-addressed valid/ready requests onto the word-indexed simulation RAM port.
// Read bursts fetch two words per cycle into a 4-entry circular response buffer.
module ram_req_bridge #(
   parameter logic [63:0] RAM_BASE  = 64'h8000_0000,
   parameter int          MAX_BEATS = 8
) (
   input logic             clk,
   input logic             rstn,
   ram_req_bridge_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_BEATS) + 1;

   typedef enum logic [2:0] {IDLE, WR, WRESP, RD, ERR} state_e;

   state_e             state_q, state_d;
   logic               ready_q, ready_d;
   logic [CNT_W-1:0]   beats_left_q, beats_left_d;
   logic [63:0]        next_idx_q, next_idx_d;
   logic [2:0]         len_q, len_d;
   logic [2:0]         delivered_q, delivered_d;
   logic [63:0]        buf_q [4];
   logic [63:0]        buf_d [4];
   logic [1:0]         wr_ptr_q, wr_ptr_d;
   logic [1:0]         rd_ptr_q, rd_ptr_d;
   logic [2:0]         count_q, count_d;
   logic [63:0]        widx_q, widx_d;
   logic [63:0]        wdata_q, wdata_d;
   logic [63:0]        wmask_q, wmask_d;
   logic [63:0]        ridx0_q, ridx0_d;
   logic [63:0]        ridx1_q, ridx1_d;

   logic               req_err;
   logic               misaligned;
   logic [63:0]        req_idx;
   logic [3:0]         req_bytes;
   logic [15:0]        lane_span;
   logic [7:0]         byte_mask;
   logic [63:0]        bit_mask;
   logic               issue;
   logic               pair;
   logic [2:0]         push_n;
   logic               resp_valid;
   logic               resp_last;
   logic               pop;

   // Request decode: index, error checks and the write byte-lane mask.
   always_comb begin
      req_idx = (bus.req_addr - RAM_BASE) >> 3;
      case (bus.req_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = bus.req_addr[0];
         2'd2:    misaligned = |bus.req_addr[1:0];
         default: misaligned = |bus.req_addr[2:0];
      endcase
      req_err = (bus.req_addr < RAM_BASE) || misaligned
             || (!bus.req_wen && (bus.req_len != 3'd0) && (bus.req_size != 2'd3))
             || (bus.req_wen && (bus.req_len != 3'd0));
      req_bytes = 4'd1 << bus.req_size;
      lane_span = (16'd1 << req_bytes) - 16'd1;
      byte_mask = 8'(lane_span << bus.req_addr[2:0]);
      bit_mask  = '0;
      for (int i = 0; i < 8; i++) begin
         bit_mask[8*i +: 8] = {8{byte_mask[i]}};
      end
   end

   // A pair push needs two free slots, so issuing is gated on occupancy <= 2.
   always_comb begin
      issue      = (state_q == RD) && (beats_left_q != '0) && (count_q <= 3'd2);
      pair       = beats_left_q >= CNT_W'(2);
      push_n     = issue ? (pair ? 3'd2 : 3'd1) : 3'd0;
      resp_valid = (state_q == WRESP) || (state_q == ERR) || ((state_q == RD) && (count_q != 3'd0));
      resp_last  = (state_q == WRESP) || (state_q == ERR)
                || ((state_q == RD) && (count_q != 3'd0) && (delivered_q == len_q));
      pop        = resp_valid && bus.resp_ready;
   end

   always_comb begin
      state_d      = state_q;
      beats_left_d = beats_left_q;
      next_idx_d   = next_idx_q;
      len_d        = len_q;
      delivered_d  = delivered_q;
      buf_d        = buf_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      widx_d       = widx_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      ridx0_d      = ridx0_q;
      ridx1_d      = ridx1_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && ready_q) begin
               len_d       = bus.req_len;
               delivered_d = 3'd0;
               if (req_err) begin
                  state_d = ERR;
               end else if (bus.req_wen) begin
                  state_d = WR;
                  widx_d  = req_idx;
                  wdata_d = bus.req_wdata;
                  wmask_d = bit_mask;
               end else begin
                  state_d      = RD;
                  beats_left_d = CNT_W'(bus.req_len) + CNT_W'(1);
                  next_idx_d   = req_idx;
               end
            end
         end
         WR: state_d = WRESP;
         WRESP, ERR: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         RD: begin
            if (issue) begin
               buf_d[wr_ptr_q] = bus.ram_rdata_0;
               if (pair) buf_d[wr_ptr_q + 2'd1] = bus.ram_rdata_1;
               wr_ptr_d     = wr_ptr_q + push_n[1:0];
               beats_left_d = beats_left_q - CNT_W'(push_n);
               next_idx_d   = next_idx_q + 64'(push_n);
               ridx0_d      = next_idx_q;
               ridx1_d      = next_idx_q + 64'd1;
            end
            if (pop) begin
               rd_ptr_d    = rd_ptr_q + 2'd1;
               delivered_d = delivered_q + 3'd1;
               if (resp_last) state_d = IDLE;
            end
            count_d = count_q + push_n - {2'b00, pop};
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         ready_q      <= 1'b0;
         beats_left_q <= '0;
         next_idx_q   <= '0;
         len_q        <= '0;
         delivered_q  <= '0;
         for (int i = 0; i < 4; i++) buf_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         widx_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         ridx0_q      <= '0;
         ridx1_q      <= '0;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         beats_left_q <= beats_left_d;
         next_idx_q   <= next_idx_d;
         len_q        <= len_d;
         delivered_q  <= delivered_d;
         for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         widx_q       <= widx_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         ridx0_q      <= ridx0_d;
         ridx1_q      <= ridx1_d;
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_rdata = ((state_q == RD) && (count_q != 3'd0)) ? buf_q[rd_ptr_q] : '0;
   assign bus.resp_last  = resp_last;
   assign bus.resp_err   = (state_q == ERR);
   assign bus.ram_en     = (state_q == WR) || issue;
   assign bus.ram_wen    = (state_q == WR);
   assign bus.ram_wmask  = (state_q == WR) ? wmask_q : '0;
   assign bus.ram_wIdx   = widx_q;
   assign bus.ram_wdata  = wdata_q;
   assign bus.ram_rIdx_0 = issue ? next_idx_q : ridx0_q;
   assign bus.ram_rIdx_1 = issue ? (next_idx_q + 64'd1) : ridx1_q;
endmodule

// File: doc/ram_req_bridge.md
# ram_req_bridge

Request-side initiator for the 2-read/1-write simulation RAM port used by the difftest memory model. Accepts byte-addressed valid/ready requests from a core-side memory master, converts them into 64-bit word-indexed RAM accesses with generated byte masks, and returns responses over a second valid/ready channel. Read bursts of up to 8 beats use both RAM read ports per cycle into a 4-entry response buffer, so a burst streams at one beat per cycle under backpressure.

## Interface
- RAM_BASE, 64'h8000_0000, byte address mapped to RAM word index 0
- MAX_BEATS, 8, maximum read burst length; req_len is beats-1
- clk  in  1  clock; all logic on posedge
- rstn  in  1  synchronous reset, active-low
- req_valid  in  1  request valid
- req_ready  out  1  bridge can accept a request
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  64  byte address
- req_size  in  2  log2 bytes: 0=1B, 1=2B, 2=4B, 3=8B
- req_len  in  3  read beats-1; must be 0 for writes
- req_wdata  in  64  write data, already placed in byte lanes
- resp_valid  out  1  response beat valid
- resp_ready  in  1  consumer accepts beat
- resp_rdata  out  64  full RAM word, unshifted; 0 for writes and errors
- resp_last  out  1  final beat of the transaction
- resp_err  out  1  transaction rejected
- ram_en  out  1  RAM enable
- ram_rIdx_0, ram_rIdx_1  out  64  read word indices
- ram_rdata_0, ram_rdata_1  in  64  read data, combinational from index
- ram_wIdx, ram_wdata, ram_wmask  out  64  write index, data, bit mask
- ram_wen  out  1  write enable

## Operation
- Word index = (req_addr - RAM_BASE) >> 3.
- Error conditions, checked at acceptance: req_addr < RAM_BASE; req_addr not aligned to 2^req_size; read with req_len>0 and req_size!=3; write with req_len!=0. On error there is no RAM access: one response beat with resp_err=1, resp_last=1, resp_rdata=0.
- States: IDLE, WR, WRESP, RD, ERR.
- IDLE: req_ready=1. On fire, latch the request. Go to ERR if any error condition holds, else WR if req_wen, else RD with beats_left=req_len+1 and next_idx=base index.
- WR: exactly one cycle. ram_en=1, ram_wen=1, ram_wIdx=index, ram_wdata=latched wdata. ram_wmask = 0xFF per enabled byte lane, covering 2^size bytes starting at addr[2:0]. Then go to WRESP.
- WRESP: resp_valid=1, resp_last=1, resp_err=0, resp_rdata=0. Go to IDLE on resp_ready.
- RD issue rule: in any cycle with beats_left>0 and buffer occupancy <=2 at cycle start:
  - ram_en=1; ram_rIdx_0=next_idx; ram_rIdx_1=next_idx+1.
  - Push rdata_0, plus rdata_1 if beats_left>=2.
  - Decrement beats_left by the number pushed; advance next_idx by the same amount.
- RD response: resp_valid = buffer non-empty; head entry is popped on resp_ready. resp_last=1 on the beat that brings the delivered count to req_len+1. Go to IDLE after the last pop.
- A push and a pop in the same cycle are both performed.
- Buffer is 4 entries, circular, with wrap-around pointers; it never overflows because a pair push requires occupancy <=2.
- ERR: drive the error beat until resp_ready, then go to IDLE.
- ram_en=0, ram_wen=0 and ram_wmask=0 whenever no access is issued. Index outputs hold their last values.
- Reset (rstn=0 sampled at posedge) from any state, including mid-burst:
  - state to IDLE; buffer empty; beats_left=0; all outputs 0.
  - Data already in flight is discarded, with no response.
  - req_ready=0 while rstn=0.

## Timing
- Write: request fire in cycle N; ram_wen high in N+1; resp_valid from N+2.
- Read: fire in N; first pair read in N+1; resp_valid with beat 0 in N+2.
  - With resp_ready held high, beats follow consecutively: a len=7 burst delivers its last beat in N+9.
- Error: fire in N; resp_valid with resp_err in N+1.
- Outputs are registered except ram_rIdx/ram_en/ram_wen, which are decoded from state and registers.
- Only one outstanding transaction: req_ready=0 outside IDLE.
- Response signals stay stable while resp_valid && !resp_ready.

## Test plan
- Write 8B at 0x8000_0010, data 0x1122334455667788: ram_wIdx=2, wmask=all ones, wen high for exactly one cycle; then a response with last=1, err=0.
- Write 2B at 0x8000_0006: ram_wIdx=0, wmask=0xFFFF_0000_0000_0000. A following 8B read at 0x8000_0000 returns the merged word.
- Read burst len=7 at 0x8000_0000, RAM preloaded word i=i: beats 0..7 in consecutive cycles from N+2, last only on beat 7, ram_rIdx_0 steps 0,2,4,6.
- Same burst with resp_ready toggling 1,0,0,1,...: no lost or duplicated beats, occupancy never exceeds 4, response outputs stable while stalled.
- Misaligned 4B read at 0x8000_0002, then read at 0x7FFF_FFF8: each gives one beat with err=1 and rdata=0 at N+1, and ram_en is never asserted.
- rstn low during beat 3 of a len=7 burst: on the next cycle resp_valid=0 and req_ready=0. After release, req_ready=1 and a new read returns correct data.
